// File: rtl/framer_pkg.sv
// Shared types and constants for sample_framer.
// SAMPLE_FRAMER_CKSUM_EN selects between the two frame lengths defined here.
package framer_pkg;

    localparam int unsigned SAMPLE_W        = 14;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned IDX_W           = 3;
    localparam int unsigned DECIM_CNT_W     = 8;
    localparam int unsigned FRAME_LEN_BASE  = 6;
    localparam int unsigned FRAME_LEN_CKSUM = 7;

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_READY
    } state_e;

    // Payload latched at capture time; serialised byte by byte afterwards.
    typedef struct packed {
        logic [BYTE_W-1:0]   seq;
        logic [SAMPLE_W-1:0] ch1;
        logic [SAMPLE_W-1:0] ch2;
    } frame_t;

    function automatic logic [BYTE_W-1:0] hi_byte(input logic [SAMPLE_W-1:0] s);
        return {2'b00, s[SAMPLE_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/sample_decimator.sv
// Qualifies sample strobes with gate/ADC-init and emits one capture event
// every DECIM qualified strobes.
module sample_decimator
    import framer_pkg::*;
#(
    parameter int unsigned DECIM = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sample_valid,
    input  logic i_gate,
    input  logic i_adc_init,
    output logic o_capture_c
);

    localparam logic [DECIM_CNT_W-1:0] LAST_CNT = DECIM_CNT_W'(DECIM - 1);

    logic [DECIM_CNT_W-1:0] cnt_q, cnt_d;

    // Count restarts from zero whenever capture is disqualified.
    always_comb begin
        cnt_d       = cnt_q;
        o_capture_c = 1'b0;
        if (!(i_gate && i_adc_init)) begin
            cnt_d = '0;
        end else if (i_sample_valid) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d       = '0;
                o_capture_c = 1'b1;
            end else begin
                cnt_d = cnt_q + DECIM_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_framer.sv
// Packs ch1/ch2 samples into header+seq+sample byte frames for a UART tx_unit.
// Define SAMPLE_FRAMER_CKSUM_EN to append an XOR checksum byte (7-byte frame).
module sample_framer
    import framer_pkg::*;
#(
    parameter int unsigned        DATA_SIZE = SAMPLE_W,
    parameter int unsigned        DECIM     = 1,
    parameter logic [BYTE_W-1:0]  HEADER    = HEADER_DEFAULT
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_SIZE-1:0] i_data_ch1,
    input  logic [DATA_SIZE-1:0] i_data_ch2,
    input  logic                 i_sample_valid,
    input  logic                 i_gate,
    input  logic                 i_adc_init,
    input  logic                 i_txready,
    output logic [BYTE_W-1:0]    o_txdata,
    output logic                 o_send,
    output logic                 o_busy,
    output logic                 o_overrun
);

`ifdef SAMPLE_FRAMER_CKSUM_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_CKSUM;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e             state_q, state_d;
    frame_t             frame_q, frame_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  seq_q, seq_d;
    logic [BYTE_W-1:0]  txdata_q, txdata_d;
    logic               send_q, send_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               capture_c;
    logic [IDX_W-1:0]   idx_next_c;

    sample_decimator #(
        .DECIM (DECIM)
    ) u_decim (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_sample_valid (i_sample_valid),
        .i_gate         (i_gate),
        .i_adc_init     (i_adc_init),
        .o_capture_c    (capture_c)
    );

    function automatic logic [BYTE_W-1:0] frame_byte(input frame_t f, input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return HEADER;
            3'd1:    return f.seq;
            3'd2:    return hi_byte(f.ch1);
            3'd3:    return f.ch1[BYTE_W-1:0];
            3'd4:    return hi_byte(f.ch2);
            3'd5:    return f.ch2[BYTE_W-1:0];
`ifdef SAMPLE_FRAMER_CKSUM_EN
            3'd6:    return f.seq ^ hi_byte(f.ch1) ^ f.ch1[BYTE_W-1:0]
                            ^ hi_byte(f.ch2) ^ f.ch2[BYTE_W-1:0];
`endif
            default: return '0;
        endcase
    endfunction

    // LOAD and SEND both fire o_send on ready so the first strobe lands two cycles after capture.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        txdata_d   = txdata_q;
        send_d     = 1'b0;
        overrun_d  = overrun_q;
        idx_next_c = idx_q + IDX_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (capture_c) begin
                    frame_d.seq = seq_q;
                    frame_d.ch1 = SAMPLE_W'(i_data_ch1);
                    frame_d.ch2 = SAMPLE_W'(i_data_ch2);
                    seq_d       = seq_q + BYTE_W'(1);
                    idx_d       = '0;
                    txdata_d    = HEADER;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD, ST_SEND: begin
                if (i_txready) begin
                    send_d  = 1'b1;
                    state_d = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_BUSY: begin
                if (!i_txready) begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (i_txready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d    = idx_next_c;
                        txdata_d = frame_byte(frame_q, idx_next_c);
                        state_d  = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture_c && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            seq_q     <= '0;
            txdata_q  <= '0;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            txdata_q  <= txdata_d;
            send_q    <= send_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_txdata  = txdata_q;
    assign o_send    = send_q;
    assign o_busy    = busy_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: DECIM=1 and DECIM=4 instances share stimulus,
// each driven by its own tx_unit responder and checked against a frame queue model.
module tb_sample_framer;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n, gate, adc_init, valid;
    logic [13:0] ch1, ch2;
    logic [1:0]       rdy, snd, busy, ovr;
    logic [1:0][7:0]  txd;

    int          n_vec = 0;
    int          n_err = 0;
    int          decim_n [2] = '{1, 4};
    int          cnt     [2];
    logic [7:0]  seq_m   [2];
    logic        ovr_m   [2];
    int          bcnt    [2];
    int          n_send  [2] = '{0, 0};
    logic [7:0]  prev_txd[2];
    logic [7:0]  eq0[$];
    logic [7:0]  eq1[$];

    always #5 clk = ~clk;

    sample_framer #(.DECIM(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_data_ch1(ch1), .i_data_ch2(ch2),
        .i_sample_valid(valid), .i_gate(gate), .i_adc_init(adc_init),
        .i_txready(rdy[0]), .o_txdata(txd[0]), .o_send(snd[0]),
        .o_busy(busy[0]), .o_overrun(ovr[0])
    );

    sample_framer #(.DECIM(4)) u_dut4 (
        .i_clock(clk), .i_reset(rst_n), .i_data_ch1(ch1), .i_data_ch2(ch2),
        .i_sample_valid(valid), .i_gate(gate), .i_adc_init(adc_init),
        .i_txready(rdy[1]), .o_txdata(txd[1]), .o_send(snd[1]),
        .o_busy(busy[1]), .o_overrun(ovr[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? eq0.size() : eq1.size();
    endfunction

    task automatic qpush(input int k, input logic [7:0] b);
        if (k == 0) eq0.push_back(b);
        else        eq1.push_back(b);
    endtask

    task automatic qpop(input int k, output logic [31:0] b);
        if (qsize(k) == 0)  b = 32'hDEAD;
        else if (k == 0)    b = 32'(eq0.pop_front());
        else                b = 32'(eq1.pop_front());
    endtask

    // Expected byte stream of one frame, built straight from the frame layout.
    task automatic push_frame(input int k, input logic [13:0] a, input logic [13:0] b);
        logic [7:0] bytes [6];
        bytes = '{HDR, seq_m[k], {2'b00, a[13:8]}, a[7:0], {2'b00, b[13:8]}, b[7:0]};
        for (int i = 0; i < 6; i++) qpush(k, bytes[i]);
`ifdef SAMPLE_FRAMER_CKSUM_EN
        qpush(k, bytes[1] ^ bytes[2] ^ bytes[3] ^ bytes[4] ^ bytes[5]);
`endif
        seq_m[k] = seq_m[k] + 8'd1;
    endtask

    function automatic logic model_busy(input int k);
        return (qsize(k) != 0) || !rdy[k];
    endfunction

    // tx_unit model: accepts a byte on o_send, then stays not-ready for a random time.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] exp_b;
            if (!rst_n) begin
                rdy[k]  = 1'b1;
                bcnt[k] = 0;
            end else begin
                if (bcnt[k] > 0) begin
                    bcnt[k]--;
                    if (bcnt[k] == 0) rdy[k] = 1'b1;
                end
                if (snd[k]) begin
                    n_send[k]++;
                    qpop(k, exp_b);
                    check_val($sformatf("byte_d%0d", decim_n[k]), 32'(txd[k]), exp_b);
                    check_val($sformatf("txdata_stable_d%0d", decim_n[k]), 32'(txd[k]), 32'(prev_txd[k]));
                    rdy[k]  = 1'b0;
                    bcnt[k] = int'($urandom_range(4, 1));
                end
            end
            prev_txd[k] = txd[k];
        end
    end

    task automatic set_qual(input logic g, input logic i);
        gate     = g;
        adc_init = i;
        if (!(g && i)) begin
            cnt[0] = 0;
            cnt[1] = 0;
        end
    endtask

    // One strobe cycle; the model decides capture/drop before the sampling edge.
    task automatic drive_cycle(input logic [13:0] a, input logic [13:0] b);
        valid = 1'b1;
        ch1   = a;
        ch2   = b;
        if (gate && adc_init) begin
            for (int k = 0; k < 2; k++) begin
                cnt[k]++;
                if (cnt[k] == decim_n[k]) begin
                    cnt[k] = 0;
                    if (model_busy(k)) ovr_m[k] = 1'b1;
                    else               push_frame(k, a, b);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        valid = 1'b0;
        while ((busy != 2'b00) && (t < 600)) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s_txdata%0d", tag, k), 32'(txd[k]), 32'd0);
            check_val($sformatf("%s_send%0d", tag, k), 32'(snd[k]), 32'd0);
            check_val($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'd0);
            check_val($sformatf("%s_ovr%0d", tag, k), 32'(ovr[k]), 32'd0);
        end
    endtask

    task automatic model_reset();
        eq0.delete();
        eq1.delete();
        for (int k = 0; k < 2; k++) begin
            cnt[k]   = 0;
            seq_m[k] = 8'd0;
            ovr_m[k] = 1'b0;
        end
    endtask

    task automatic check_ovr(input string tag);
        for (int k = 0; k < 2; k++)
            check_val($sformatf("%s_ovr_d%0d", tag, decim_n[k]), 32'(ovr[k]), 32'(ovr_m[k]));
    endtask

    initial begin
        int s0, s1, tgt, t;
        rst_n = 1'b0; valid = 1'b0; ch1 = '0; ch2 = '0;
        set_qual(1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        set_qual(1'b1, 1'b1);
        @(negedge clk);

        // Known frame: capture, LOAD one cycle later, first send the cycle after.
        drive_cycle(14'h1ABC, 14'h0123);
        valid = 1'b0;
        check_val("load_busy", 32'(busy[0]), 32'd1);
        check_val("load_hdr", 32'(txd[0]), 32'(HDR));
        check_val("load_nosend", 32'(snd[0]), 32'd0);
        @(negedge clk);
        check_val("first_send", 32'(snd[0]), 32'd1);
        wait_idle("known");

        // Spaced random strobes: every strobe framed at DECIM=1, every 4th at DECIM=4.
        repeat (12) begin
            drive_cycle(14'($urandom), 14'($urandom));
            wait_idle("spaced");
        end
        check_ovr("spaced");

        // Disqualified strobes must not start a frame.
        s0 = n_send[0]; s1 = n_send[1];
        set_qual(1'b0, 1'b1);
        repeat (8) drive_cycle(14'($urandom), 14'($urandom));
        set_qual(1'b1, 1'b0);
        repeat (8) drive_cycle(14'($urandom), 14'($urandom));
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("gated_send_d1", 32'(n_send[0] - s0), 32'd0);
        check_val("gated_send_d4", 32'(n_send[1] - s1), 32'd0);

        // Gate falling mid-frame leaves the frame to complete.
        set_qual(1'b1, 1'b1);
        drive_cycle(14'($urandom), 14'($urandom));
        valid = 1'b0;
        repeat (6) @(negedge clk);
        set_qual(1'b0, 1'b1);
        wait_idle("gatefall");
        check_val("gatefall_left_d1", 32'(qsize(0)), 32'd0);
        set_qual(1'b1, 1'b1);

        // Back-to-back strobes while busy: one frame each, overrun sticks.
        set_qual(1'b0, 1'b1);
        @(negedge clk);
        set_qual(1'b1, 1'b1);
        check_ovr("pre_burst");
        repeat (16) drive_cycle(14'($urandom), 14'($urandom));
        valid = 1'b0;
        check_ovr("burst");
        wait_idle("burst");
        check_ovr("post_burst");

        // Enough frames to wrap the sequence byte.
        repeat (256) begin
            drive_cycle(14'($urandom), 14'($urandom));
            wait_idle("wrap");
        end
        check_ovr("wrap");
        check_val("wrap_left_d1", 32'(qsize(0)), 32'd0);
        check_val("wrap_left_d4", 32'(qsize(1)), 32'd0);

        // Reset in the middle of a frame abandons it.
        drive_cycle(14'($urandom), 14'($urandom));
        valid = 1'b0;
        tgt = n_send[0] + 3;
        t = 0;
        while ((n_send[0] < tgt) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        check_val("midframe_reached", 32'(n_send[0] >= tgt), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        model_reset();
        rst_n = 1'b1;
        s0 = n_send[0]; s1 = n_send[1];
        repeat (6) @(negedge clk);
        check_val("post_reset_send_d1", 32'(n_send[0] - s0), 32'd0);
        check_val("post_reset_send_d4", 32'(n_send[1] - s1), 32'd0);
        drive_cycle(14'($urandom), 14'($urandom));
        wait_idle("after_reset");
        check_val("after_reset_left_d1", 32'(qsize(0)), 32'd0);
        check_val("after_reset_sends", 32'(n_send[0] - s0), 32'd6
`ifdef SAMPLE_FRAMER_CKSUM_EN
            + 32'd1
`endif
        );
        check_ovr("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
